// File: rtl/key_code_capture.sv
// Key-bank front end: synchronises raw keys, detects fresh presses, encodes each
// press to a symbol and packs DIGITS symbols into a code word with valid/ack.
module key_code_capture #(
  parameter int N_KEYS = 4,
  parameter int SYM_W  = 2,
  parameter int DIGITS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_KEYS-1:0]              keys,
  input  logic                           clear,
  input  logic                           ack,
  output logic [SYM_W-1:0]               sym,
  output logic                           sym_valid,
  output logic                           multi_err,
  output logic                           drop_err,
  output logic [DIGITS*SYM_W-1:0]        code,
  output logic [$clog2(DIGITS+1)-1:0]    count,
  output logic                           code_valid
);

  localparam int CNT_W = $clog2(DIGITS + 1);

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

  state_e state, state_next;

  logic [N_KEYS-1:0]       sync1, sync2, hist;
  logic                    press, multi;
  logic [SYM_W-1:0]        idx;

  logic [SYM_W-1:0]        sym_next;
  logic                    sym_valid_next, multi_err_next, drop_err_next;
  logic [DIGITS*SYM_W-1:0] code_next;
  logic [CNT_W-1:0]        count_next;
  logic                    code_valid_next;

  // Synchroniser and history reset to all-ones so a key held through reset
  // release never looks like a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
      hist  <= '1;
    end else begin
      // NOTE: non-blocking assignments make the three stages shift together;
      // blocking ones would collapse the chain into a single flop.
      sync1 <= keys;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign press = (sync2 != '0) && (hist == '0);
  assign multi = |(sync2 & (sync2 - N_KEYS'(1)));

  // Highest set index wins: later iterations override earlier ones.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (sync2[i]) idx = SYM_W'(i);
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_next      = state;
    sym_next        = sym;
    sym_valid_next  = 1'b0;
    multi_err_next  = 1'b0;
    drop_err_next   = 1'b0;
    code_next       = code;
    count_next      = count;
    code_valid_next = code_valid;

    if (clear) begin
      state_next      = COLLECT;
      code_next       = '0;
      count_next      = '0;
      code_valid_next = 1'b0;
    end else begin
      unique case (state)
        COLLECT: begin
          if (press) begin
            if (multi) begin
              multi_err_next = 1'b1;
            end else begin
              for (int k = 0; k < DIGITS; k++) begin
                if (count == CNT_W'(k)) code_next[k*SYM_W +: SYM_W] = idx;
              end
              sym_next       = idx;
              sym_valid_next = 1'b1;
              count_next     = count + CNT_W'(1);
              if (count == CNT_W'(DIGITS - 1)) begin
                code_valid_next = 1'b1;
                state_next      = FULL;
              end
            end
          end
        end
        FULL: begin
          // A press while full is reported but never stored, even on the ack edge.
          if (press) begin
            if (multi) multi_err_next = 1'b1;
            else       drop_err_next  = 1'b1;
          end
          if (ack) begin
            code_next       = '0;
            count_next      = '0;
            code_valid_next = 1'b0;
            state_next      = COLLECT;
          end
        end
        default: state_next = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT;
      sym        <= '0;
      sym_valid  <= 1'b0;
      multi_err  <= 1'b0;
      drop_err   <= 1'b0;
      code       <= '0;
      count      <= '0;
      code_valid <= 1'b0;
    end else begin
      state      <= state_next;
      sym        <= sym_next;
      sym_valid  <= sym_valid_next;
      multi_err  <= multi_err_next;
      drop_err   <= drop_err_next;
      code       <= code_next;
      count      <= count_next;
      code_valid <= code_valid_next;
    end
  end

endmodule

// File: tb/tb_key_code_capture.sv
// Directed bench for key_code_capture: a 4-key/4-digit instance and an
// 8-key/5-digit instance sharing clock and reset.
module tb_key_code_capture;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: N_KEYS=4, SYM_W=2, DIGITS=4
  logic [3:0]  keys_a;
  logic        clear_a, ack_a;
  logic [1:0]  sym_a;
  logic        sym_valid_a, multi_err_a, drop_err_a;
  logic [7:0]  code_a;
  logic [2:0]  count_a;
  logic        code_valid_a;

  // Instance B: N_KEYS=8, SYM_W=3, DIGITS=5
  logic [7:0]  keys_b;
  logic        clear_b, ack_b;
  logic [2:0]  sym_b;
  logic        sym_valid_b, multi_err_b, drop_err_b;
  logic [14:0] code_b;
  logic [2:0]  count_b;
  logic        code_valid_b;

  key_code_capture #(.N_KEYS(4), .SYM_W(2), .DIGITS(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .keys(keys_a), .clear(clear_a), .ack(ack_a),
    .sym(sym_a), .sym_valid(sym_valid_a), .multi_err(multi_err_a),
    .drop_err(drop_err_a), .code(code_a), .count(count_a),
    .code_valid(code_valid_a)
  );

  key_code_capture #(.N_KEYS(8), .SYM_W(3), .DIGITS(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .keys(keys_b), .clear(clear_b), .ack(ack_b),
    .sym(sym_b), .sym_valid(sym_valid_b), .multi_err(multi_err_b),
    .drop_err(drop_err_b), .code(code_b), .count(count_b),
    .code_valid(code_valid_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a key pattern at a falling edge; return just after the third rising edge.
  task automatic press_a(input logic [3:0] k);
    keys_a = k;
    repeat (3) @(negedge clk);
  endtask

  task automatic release_a();
    keys_a = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic press_b(input logic [7:0] k);
    keys_b = k;
    repeat (3) @(negedge clk);
  endtask

  task automatic release_b();
    keys_b = '0;
    repeat (4) @(negedge clk);
  endtask

  logic seen;
  logic [3:0] seq_keys [4];
  logic [1:0] seq_sym  [4];

  initial begin
    seq_keys[0] = 4'b0001; seq_sym[0] = 2'd0;
    seq_keys[1] = 4'b0010; seq_sym[1] = 2'd1;
    seq_keys[2] = 4'b0100; seq_sym[2] = 2'd2;
    seq_keys[3] = 4'b1000; seq_sym[3] = 2'd3;

    rst_n = 1'b0;
    keys_a = 4'b0100; clear_a = 1'b0; ack_a = 1'b0;
    keys_b = '0;      clear_b = 1'b0; ack_b = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_code",  {24'd0, code_a}, 32'd0);
    check("rst_count", {29'd0, count_a}, 32'd0);
    check("rst_flags", {28'd0, sym_valid_a, multi_err_a, drop_err_a, code_valid_a}, 32'd0);
    check("rst_sym",   {30'd0, sym_a}, 32'd0);

    // 1: key held through reset release is not a press
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | sym_valid_a | multi_err_a;
    end
    check("held_no_press", {31'd0, seen}, 32'd0);
    check("held_count", {29'd0, count_a}, 32'd0);
    release_a();
    press_a(4'b0100);
    check("repress_valid", {31'd0, sym_valid_a}, 32'd1);
    check("repress_sym",   {30'd0, sym_a}, 32'd2);
    check("repress_count", {29'd0, count_a}, 32'd1);
    release_a();
    clear_a = 1'b1;
    @(negedge clk);
    clear_a = 1'b0;
    check("clear_count", {29'd0, count_a}, 32'd0);
    check("clear_sym_kept", {30'd0, sym_a}, 32'd2);

    // 2: four single-key presses fill the code; first one checks latency
    for (int d = 0; d < 4; d++) begin
      keys_a = seq_keys[d];
      repeat (2) @(negedge clk);
      if (d == 0) check("latency_2edges", {31'd0, sym_valid_a}, 32'd0);
      @(negedge clk);
      check($sformatf("seq%0d_valid", d), {31'd0, sym_valid_a}, 32'd1);
      check($sformatf("seq%0d_sym", d),   {30'd0, sym_a}, {30'd0, seq_sym[d]});
      check($sformatf("seq%0d_count", d), {29'd0, count_a}, d + 1);
      keys_a = '0;
      @(negedge clk);
      if (d == 0) check("pulse_1cycle", {31'd0, sym_valid_a}, 32'd0);
      repeat (3) @(negedge clk);
    end
    check("full_code",  {24'd0, code_a}, 32'hE4);
    check("full_valid", {31'd0, code_valid_a}, 32'd1);

    // 4: press while full is dropped; ack empties the code
    press_a(4'b0001);
    check("drop_err", {29'd0, drop_err_a, sym_valid_a, multi_err_a}, 32'b100);
    check("drop_code", {24'd0, code_a}, 32'hE4);
    check("drop_count", {29'd0, count_a}, 32'd4);
    release_a();
    ack_a = 1'b1;
    @(negedge clk);
    ack_a = 1'b0;
    check("ack_code",  {24'd0, code_a}, 32'd0);
    check("ack_count", {29'd0, count_a}, 32'd0);
    check("ack_valid", {31'd0, code_valid_a}, 32'd0);

    // 3: two keys at once -> multi_err only, sym keeps last value
    press_a(4'b0110);
    check("multi_flags", {29'd0, multi_err_a, sym_valid_a, drop_err_a}, 32'b100);
    check("multi_count", {29'd0, count_a}, 32'd0);
    check("multi_sym",   {30'd0, sym_a}, 32'd3);
    @(negedge clk);
    check("multi_1cycle", {31'd0, multi_err_a}, 32'd0);
    release_a();
    press_a(4'b0100);
    check("after_multi_sym", {30'd0, sym_a}, 32'd2);
    release_a();
    press_a(4'b1000);
    check("two_digit_code",  {24'd0, code_a}, 32'h0E);
    check("two_digit_count", {29'd0, count_a}, 32'd2);
    release_a();

    // 5: clear on the same edge as a press wins
    keys_a = 4'b0001;
    repeat (2) @(negedge clk);
    clear_a = 1'b1;
    @(negedge clk);
    clear_a = 1'b0;
    check("clr_press_count", {29'd0, count_a}, 32'd0);
    check("clr_press_flags", {29'd0, sym_valid_a, multi_err_a, drop_err_a}, 32'd0);
    check("clr_press_sym",   {30'd0, sym_a}, 32'd3);
    release_a();
    press_a(4'b0010);
    check("pre_rst_count", {29'd0, count_a}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_code",  {24'd0, code_a}, 32'd0);
    check("midrst_count", {29'd0, count_a}, 32'd0);
    check("midrst_sym",   {30'd0, sym_a}, 32'd0);
    check("midrst_flags", {28'd0, sym_valid_a, multi_err_a, drop_err_a, code_valid_a}, 32'd0);
    @(negedge clk);
    keys_a = '0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 6: wide instance, five presses of key 7, then key 5+7 together
    for (int d = 0; d < 5; d++) begin
      press_b(8'h80);
      check($sformatf("b_seq%0d_sym", d), {29'd0, sym_b}, 32'd7);
      release_b();
    end
    check("b_code",  {17'd0, code_b}, 32'h7FFF);
    check("b_count", {29'd0, count_b}, 32'd5);
    check("b_valid", {31'd0, code_valid_b}, 32'd1);
    press_b(8'hA0);
    check("b_multi", {29'd0, multi_err_b, drop_err_b, sym_valid_b}, 32'b100);
    check("b_code_frozen", {17'd0, code_b}, 32'h7FFF);
    release_b();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
